// File: rtl/fwrisc_ipf_pkg.sv
// Shared constants and helpers for the instruction prefetcher.
//   TAG_W          : word tag width (address bits [31:2])
//   ST_*           : controller state encodings
//   word_tag/tag_addr : address <-> word tag conversion
package fwrisc_ipf_pkg;

  localparam int unsigned TAG_W = 30;
  localparam int unsigned ST_W  = 2;

  localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [ST_W-1:0] ST_DEMAND   = 2'd1;
  localparam logic [ST_W-1:0] ST_PREFETCH = 2'd2;
  localparam logic [ST_W-1:0] ST_DROP     = 2'd3;

  function automatic logic [TAG_W-1:0] word_tag(input logic [31:0] addr);
    return addr[31:2];
  endfunction

  function automatic logic [31:0] tag_addr(input logic [TAG_W-1:0] tag);
    return {tag, 2'b00};
  endfunction

endpackage

// File: rtl/fwrisc_ipf_fifo.sv
// Circular FIFO of sequential instruction words, tagged by a single head tag.
//   push_i/push_data_i/push_tag_i : append a word (tag used only when empty)
//   pop_i                         : drop head word, head tag advances by one
//   clear_i                       : empty the FIFO (wins over push/pop)
//   head_data_o/head_tag_o        : head entry; count_o/full_o/empty_o status
module fwrisc_ipf_fifo
  import fwrisc_ipf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [31:0]      push_data_i,
  input  logic [TAG_W-1:0] push_tag_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [31:0]      head_data_o,
  output logic [TAG_W-1:0] head_tag_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TAG_W-1:0] head_tag_q, head_tag_d;
  logic             do_push, do_pop;

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q];
  assign head_tag_o  = head_tag_q;

  // A push into a full FIFO is only legal alongside a pop.
  assign do_pop  = pop_i && !clear_i && !empty_o;
  assign do_push = push_i && !clear_i && (!full_o || do_pop);

  // Pointer, count and head-tag update.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    head_tag_d = head_tag_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
      // Entries are consecutive words, so the head tag simply steps on pop.
      if (empty_o && do_push) head_tag_d = push_tag_i;
      else if (do_pop)        head_tag_d = head_tag_q + TAG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_tag_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_tag_q <= head_tag_d;
    end
  end

  // Data storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fwrisc_iprefetch.sv
// Instruction fetch front end with a current-word register and a sequential
// prefetch FIFO. One memory request outstanding at a time.
//   clock, reset_n                : clock, async active-low reset
//   c_iaddr/c_ivalid -> c_idata/c_iready : core fetch request / response strobe
//   flush                         : drop current word, FIFO and in-flight data
//   m_iaddr/m_ivalid <- m_idata/m_iready : memory read request / completion
module fwrisc_iprefetch
  import fwrisc_ipf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter bit ENABLE_PREFETCH = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] c_iaddr,
  input  logic        c_ivalid,
  output logic [31:0] c_idata,
  output logic        c_iready,
  input  logic        flush,
  output logic [31:0] m_iaddr,
  output logic        m_ivalid,
  input  logic [31:0] m_idata,
  input  logic        m_iready
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
  logic [31:0]      cur_data_q, cur_data_d;
  logic             cur_valid_q, cur_valid_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d;
  logic             pend_q, pend_d;
  logic             c_iready_q, c_iready_d;
  logic [31:0]      c_idata_q, c_idata_d;
  logic             m_ivalid_q, m_ivalid_d;
  logic [31:0]      m_iaddr_q, m_iaddr_d;

  logic             fifo_push, fifo_pop, fifo_clear;
  logic [31:0]      fifo_head_data;
  logic [TAG_W-1:0] fifo_head_tag;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;

  logic [TAG_W-1:0] req_tag, pf_tag;
  logic             accept, lookup_ok, cur_hit, head_hit, pf_match, miss;

  assign c_iready = c_iready_q;
  assign c_idata  = c_idata_q;
  assign m_ivalid = m_ivalid_q;
  assign m_iaddr  = m_iaddr_q;

  fwrisc_ipf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clock),
    .rst_n       (reset_n),
    .push_i      (fifo_push),
    .push_data_i (m_idata),
    .push_tag_i  (word_tag(m_iaddr_q)),
    .pop_i       (fifo_pop),
    .clear_i     (fifo_clear),
    .head_data_o (fifo_head_data),
    .head_tag_o  (fifo_head_tag),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Request classification; a pending request blocks new acceptance.
  assign req_tag   = word_tag(c_iaddr);
  assign accept    = c_ivalid && !c_iready_q && !pend_q;
  assign lookup_ok = accept && !flush;
  assign cur_hit   = lookup_ok && cur_valid_q && (cur_tag_q == req_tag);
  assign head_hit  = lookup_ok && !cur_hit && !fifo_empty && (fifo_head_tag == req_tag);
  assign pf_match  = lookup_ok && !cur_hit && !head_hit && (state_q == ST_PREFETCH)
                     && (word_tag(m_iaddr_q) == req_tag);
  assign miss      = accept && !cur_hit && !head_hit && !pf_match;
  // Next sequential word after current and everything already buffered.
  assign pf_tag    = cur_tag_q + TAG_W'(fifo_count) + TAG_W'(1);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cur_tag_d   = cur_tag_q;
    cur_data_d  = cur_data_q;
    cur_valid_d = cur_valid_q;
    req_tag_d   = req_tag_q;
    pend_d      = pend_q;
    c_iready_d  = 1'b0;
    c_idata_d   = c_idata_q;
    m_ivalid_d  = m_ivalid_q;
    m_iaddr_d   = m_iaddr_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_clear  = 1'b0;

    if (flush) begin
      cur_valid_d = 1'b0;
      fifo_clear  = 1'b0 | 1'b1;
    end

    // Buffered hits are served identically in every state.
    if (cur_hit) begin
      c_iready_d = 1'b1;
      c_idata_d  = cur_data_q;
    end else if (head_hit) begin
      c_iready_d  = 1'b1;
      c_idata_d   = fifo_head_data;
      cur_tag_d   = fifo_head_tag;
      cur_data_d  = fifo_head_data;
      cur_valid_d = 1'b1;
      fifo_pop    = 1'b1;
    end

    if (miss) begin
      pend_d     = 1'b1;
      req_tag_d  = req_tag;
      fifo_clear = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (miss) begin
          state_d    = ST_DEMAND;
          m_ivalid_d = 1'b1;
          m_iaddr_d  = tag_addr(req_tag);
        end else if (ENABLE_PREFETCH && !flush && !accept && cur_valid_q && !fifo_full) begin
          state_d    = ST_PREFETCH;
          m_ivalid_d = 1'b1;
          m_iaddr_d  = tag_addr(pf_tag);
        end
      end
      ST_DEMAND: begin
        if (m_iready && !flush) begin
          state_d     = ST_IDLE;
          m_ivalid_d  = 1'b0;
          pend_d      = 1'b0;
          c_iready_d  = 1'b1;
          c_idata_d   = m_idata;
          cur_tag_d   = req_tag_q;
          cur_data_d  = m_idata;
          cur_valid_d = 1'b1;
        end else if (flush && !m_iready) begin
          state_d = ST_DROP;
        end
        // flush coinciding with m_iready: discard and reissue the same address.
      end
      ST_PREFETCH: begin
        if (flush || miss) begin
          if (!m_iready) begin
            state_d = ST_DROP;
          end else if (pend_d) begin
            state_d   = ST_DEMAND;
            m_iaddr_d = tag_addr(req_tag_d);
          end else begin
            state_d    = ST_IDLE;
            m_ivalid_d = 1'b0;
          end
        end else if (pend_q || pf_match) begin
          if (m_iready) begin
            // Core jumped past buffered words, so the FIFO no longer follows current.
            state_d     = ST_IDLE;
            m_ivalid_d  = 1'b0;
            pend_d      = 1'b0;
            c_iready_d  = 1'b1;
            c_idata_d   = m_idata;
            cur_tag_d   = word_tag(m_iaddr_q);
            cur_data_d  = m_idata;
            cur_valid_d = 1'b1;
            fifo_clear  = 1'b1;
          end else if (pf_match) begin
            pend_d    = 1'b1;
            req_tag_d = req_tag;
          end
        end else if (m_iready) begin
          state_d    = ST_IDLE;
          m_ivalid_d = 1'b0;
          fifo_push  = 1'b1;
        end
      end
      ST_DROP: begin
        if (m_iready) begin
          if (pend_d) begin
            state_d   = ST_DEMAND;
            m_iaddr_d = tag_addr(req_tag_d);
          end else begin
            state_d    = ST_IDLE;
            m_ivalid_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cur_tag_q   <= '0;
      cur_data_q  <= '0;
      cur_valid_q <= 1'b0;
      req_tag_q   <= '0;
      pend_q      <= 1'b0;
      c_iready_q  <= 1'b0;
      c_idata_q   <= '0;
      m_ivalid_q  <= 1'b0;
      m_iaddr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_tag_q   <= cur_tag_d;
      cur_data_q  <= cur_data_d;
      cur_valid_q <= cur_valid_d;
      req_tag_q   <= req_tag_d;
      pend_q      <= pend_d;
      c_iready_q  <= c_iready_d;
      c_idata_q   <= c_idata_d;
      m_ivalid_q  <= m_ivalid_d;
      m_iaddr_q   <= m_iaddr_d;
    end
  end

endmodule

// File: tb/tb_fwrisc_iprefetch.sv
// Scoreboard bench for fwrisc_iprefetch: a latency-programmable memory model,
// a core-side fetch driver pushing expected words, and a response monitor.
module tb_fwrisc_iprefetch;

  logic        clock;
  logic        reset_n;
  logic [31:0] c_iaddr;
  logic        c_ivalid;
  logic [31:0] c_idata;
  logic        c_iready;
  logic        flush;
  logic [31:0] m_iaddr;
  logic        m_ivalid;
  logic [31:0] m_idata;
  logic        m_iready;

  int n_total = 0;
  int n_bad   = 0;
  int lat     = 3;
  int mcnt    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_log[$];

  fwrisc_iprefetch #(.DEPTH(2), .ENABLE_PREFETCH(1'b1)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .c_iaddr  (c_iaddr),
    .c_ivalid (c_ivalid),
    .c_idata  (c_idata),
    .c_iready (c_iready),
    .flush    (flush),
    .m_iaddr  (m_iaddr),
    .m_ivalid (m_ivalid),
    .m_idata  (m_idata),
    .m_iready (m_iready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h8000_0000) return 32'h0000_0013;
    return addr ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory slave: completes each request lat+1 falling edges after it appears.
  always @(negedge clock) begin
    if (!reset_n) begin
      m_iready = 1'b0;
      mcnt     = 0;
    end else if (m_iready) begin
      m_iready = 1'b0;
    end else if (m_ivalid) begin
      if (mcnt >= lat) begin
        m_iready = 1'b1;
        m_idata  = mem_word(m_iaddr);
        mem_log.push_back(m_iaddr);
        mcnt     = 0;
      end else begin
        mcnt++;
      end
    end else begin
      mcnt = 0;
    end
  end

  // Response monitor: every c_iready pops one expected word.
  always @(negedge clock) begin
    if (reset_n && c_iready) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check("c_idata", c_idata, exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Issue one core fetch; exp_lat < 0 skips the latency comparison.
  task automatic fetch(input logic [31:0] addr, input int exp_lat);
    int n;
    bit seen;
    @(negedge clock);
    exp_q.push_back(mem_word(addr));
    c_iaddr  = addr;
    c_ivalid = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clock);
      n++;
      if (c_iready) seen = 1'b1;
    end
    c_ivalid = 1'b0;
    check("fetch_done", 32'(seen), 32'd1);
    if (exp_lat >= 0) check("latency", 32'(n), 32'(exp_lat));
  endtask

  initial begin
    int n;
    bit seen;
    reset_n  = 1'b0;
    c_iaddr  = '0;
    c_ivalid = 1'b0;
    flush    = 1'b0;
    m_idata  = '0;
    m_iready = 1'b0;
    idle(3);
    check("rst_c_iready", 32'(c_iready), 32'd0);
    check("rst_c_idata",  c_idata,       32'd0);
    check("rst_m_ivalid", 32'(m_ivalid), 32'd0);
    check("rst_m_iaddr",  m_iaddr,       32'd0);
    reset_n = 1'b1;

    // Cold demand fetch, then the FIFO fills with the next two words.
    fetch(32'h8000_0000, 5);
    idle(20);
    check("log_size_t1", 32'(mem_log.size()), 32'd3);
    check("pf_addr_1",   mem_log[1], 32'h8000_0004);
    check("pf_addr_2",   mem_log[2], 32'h8000_0008);
    check("idle_full",   32'(m_ivalid), 32'd0);

    // Sequential FIFO hits, then a refill prefetch.
    fetch(32'h8000_0004, 1);
    fetch(32'h8000_0008, 1);
    idle(30);
    check("log_size_t2", 32'(mem_log.size()), 32'd5);
    check("pf_addr_3",   mem_log[3], 32'h8000_000C);
    check("pf_addr_4",   mem_log[4], 32'h8000_0010);

    // Backward jump misses; repeated same-word fetches come from current.
    fetch(32'h8000_0004, 5);
    idle(30);
    check("log_size_t3", 32'(mem_log.size()), 32'd8);
    fetch(32'h8000_0004, 1);
    fetch(32'h8000_0004, 1);
    idle(10);
    check("no_refetch", 32'(mem_log.size()), 32'd8);

    // Flush with FIFO full, then the current address must miss.
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    fetch(32'h8000_0004, 5);
    check("flush_refetch", mem_log[mem_log.size()-1], 32'h8000_0004);
    lat = 5;

    // Branch while the 0x8000000C prefetch is stalled in memory.
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clock);
      n++;
      if (m_ivalid && m_iaddr == 32'h8000_000C) seen = 1'b1;
    end
    check("pf_0c_seen", 32'(seen), 32'd1);
    fetch(32'h8000_1000, -1);
    check("dropped_pf",   mem_log[mem_log.size()-2], 32'h8000_000C);
    check("branch_fetch", mem_log[mem_log.size()-1], 32'h8000_1000);
    idle(40);

    // Reset asserted in the middle of a demand fetch.
    @(negedge clock);
    c_iaddr  = 32'h8000_2000;
    c_ivalid = 1'b1;
    idle(2);
    check("demand_valid", 32'(m_ivalid), 32'd1);
    check("demand_addr",  m_iaddr, 32'h8000_2000);
    reset_n = 1'b0;
    #1;
    check("arst_c_iready", 32'(c_iready), 32'd0);
    check("arst_c_idata",  c_idata,       32'd0);
    check("arst_m_ivalid", 32'(m_ivalid), 32'd0);
    check("arst_m_iaddr",  m_iaddr,       32'd0);
    c_ivalid = 1'b0;
    lat = 3;
    idle(2);
    reset_n = 1'b1;

    fetch(32'h8000_0000, 5);
    idle(3);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fwrisc_iprefetch.md
FWRISC_IPREFETCH -- requirements
Module: fwrisc_iprefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of prefetch FIFO entries (power of two, 2..8).
REQ-002 SHALL have parameter ENABLE_PREFETCH, default 1; when 0, only demand fetches are issued and the FIFO stays empty.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; the ports are named clock and reset_n.
REQ-004 Ports: clock in 1, rising-edge clock.
REQ-005 Ports: reset_n in 1, asynchronous active-low reset.
REQ-006 Ports: c_iaddr in 32, core fetch address (bits [1:0] ignored).
REQ-007 Ports: c_ivalid in 1, core fetch request, held until c_iready.
REQ-008 Ports: c_idata out 32, instruction word, valid while c_iready.
REQ-009 Ports: c_iready out 1, one-cycle response strobe.
REQ-010 Ports: flush in 1, invalidates all buffered and in-flight words (fence.i, soft reset).
REQ-011 Ports: m_iaddr out 32, memory address, word-aligned.
REQ-012 Ports: m_ivalid out 1, memory request, held until m_iready.
REQ-013 Ports: m_idata in 32, memory read data.
REQ-014 Ports: m_iready in 1, memory completion strobe.

Function
REQ-015 A core request SHALL be accepted when c_ivalid=1 and c_iready=0; c_ivalid is ignored in the c_iready cycle.
REQ-016 Storage SHALL be a current register {tag[31:2], data, valid} plus a DEPTH-entry circular FIFO of sequential words, tagged by head tag.
REQ-017 A current hit (tag match, valid) SHALL assert c_iready with current data in the cycle after acceptance, with no state change; this serves repeated same-word fetches (compressed instructions).
REQ-018 A FIFO head hit SHALL assert c_iready one cycle after acceptance, move the head into current and pop the FIFO.
REQ-019 Any other address is a miss: the FIFO is cleared and a demand fetch is issued; c_iready SHALL assert the cycle after m_iready, and the word is loaded into current.
REQ-020 State machine: IDLE, DEMAND, PREFETCH, DROP; all outputs are registered.
REQ-021 IDLE->DEMAND on a miss; IDLE->PREFETCH when ENABLE_PREFETCH=1, current is valid, the FIFO is not full and no request is pending.
REQ-022 The PREFETCH address SHALL be current tag+1+FIFO count (32-bit wrap from 0xFFFFFFFC to 0); on m_iready the word is pushed and the state returns to IDLE.
REQ-023 A miss or flush during PREFETCH SHALL go to DROP; m_ivalid and m_iaddr are held (no cancellation), the returning data is discarded, then the state goes to DEMAND (miss) or IDLE (flush only).
REQ-024 A request that matches the in-flight prefetch address SHALL wait in PREFETCH and be served the cycle after m_iready, loading current without pushing.
REQ-025 Flush SHALL clear current.valid and the FIFO the same cycle; flush during DEMAND converts it to DROP and the pending core request is re-fetched.
REQ-026 When the FIFO is full, no prefetch SHALL be issued; FIFO count never exceeds DEPTH.
REQ-027 At most one memory request SHALL be outstanding at any time.

Reset
REQ-028 On reset_n=0, asynchronously: state=IDLE, c_iready=0, c_idata=0, m_ivalid=0, m_iaddr=0, current.valid=0, FIFO count/pointers=0.
REQ-029 Reset asserted mid-transaction SHALL abandon it; the memory slave is required to accept the m_ivalid drop.

Structure
REQ-030 The state enum and word-tag width constant SHALL reside in package fwrisc_ipf_pkg.
REQ-031 The FIFO SHALL be a sub-module fwrisc_ipf_fifo (push, pop, clear, head data/tag, count, full, empty).

Verification
REQ-032 After reset, request 0x80000000, memory returns 0x00000013 after 3 cycles -> c_iready the cycle after m_iready, c_idata=0x00000013, then prefetches to 0x80000004 and 0x80000008.
REQ-033 Sequential requests 0x80000004 and 0x80000008 after the FIFO fills -> each is served with 1-cycle latency with no m_ivalid for them; a new prefetch of 0x8000000C follows.
REQ-034 Same address 0x80000004 requested twice -> both are served from current, the FIFO count is unchanged.
REQ-035 Branch to 0x80001000 during a prefetch of 0x8000000C with memory stalled 5 cycles -> the prefetch data is dropped, then a demand fetch of 0x80001000, and c_idata equals the 0x80001000 word.
REQ-036 flush pulsed with the FIFO full, then a request to the current address -> miss, demand fetch issued; reset_n low mid-DEMAND -> all outputs 0 immediately.
